// File: rtl/bsg_counter_clear_up_down_multi_pkg.sv
// Shared types and width helpers for the clear/up/down counter bank.
// Exports: bsg_counter_mode_e, bsg_counter_cw(), bsg_counter_sw().
package bsg_counter_pkg;

  typedef enum logic {
    e_counter_sat,
    e_counter_wrap
  } bsg_counter_mode_e;

  function automatic int bsg_counter_cw(input int max_val);
    return $clog2(max_val + 1);
  endfunction

  function automatic int bsg_counter_sw(input int max_step);
    return $clog2(max_step + 1);
  endfunction

endpackage

// File: rtl/bsg_counter_clear_up_down_multi_if.sv
// Bundle of per-channel controls and status for the counter bank.
// master drives clear/up/down; slave returns count/zero/max/ovf/unf.
interface bsg_counter_clear_up_down_multi_if
  import bsg_counter_pkg::*;
#(
  parameter int els_p      = 1,
  parameter int max_val_p  = 15,
  parameter int max_step_p = 1
);

  localparam int cw = bsg_counter_cw(max_val_p);
  localparam int sw = bsg_counter_sw(max_step_p);

  logic [els_p-1:0]    clear_i;
  logic [els_p*sw-1:0] up_i;
  logic [els_p*sw-1:0] down_i;
  logic [els_p*cw-1:0] count_o;
  logic [els_p-1:0]    zero_o;
  logic [els_p-1:0]    max_o;
  logic [els_p-1:0]    ovf_o;
  logic [els_p-1:0]    unf_o;

  modport master (
    output clear_i, up_i, down_i,
    input  count_o, zero_o, max_o,
    input  ovf_o, unf_o
  );

  modport slave (
    input  clear_i, up_i, down_i,
    output count_o, zero_o, max_o,
    output ovf_o, unf_o
  );

endinterface

// File: rtl/bsg_counter_clear_up_down_ch.sv
// One counter channel: count reg, clear/up/down arithmetic, flags.
// Ports: clk_i, reset_n_i, clear_i, up_i, down_i, count_o, zero_o,
// max_o, ovf_o, unf_o. Sticky flags: BSG_COUNTER_STICKY_FLAGS_EN.
module bsg_counter_clear_up_down_ch
  import bsg_counter_pkg::*;
#(
  parameter int max_val_p  = 15,
  parameter int max_step_p = 1,
  parameter int init_val_p = 0,
  parameter bsg_counter_mode_e mode_p = e_counter_sat,
  localparam int cw = bsg_counter_cw(max_val_p),
  localparam int sw = bsg_counter_sw(max_step_p)
) (
  input  logic          clk_i,
  input  logic          reset_n_i,
  input  logic          clear_i,
  input  logic [sw-1:0] up_i,
  input  logic [sw-1:0] down_i,
  output logic [cw-1:0] count_o,
  output logic          zero_o,
  output logic          max_o,
  output logic          ovf_o,
  output logic          unf_o
);

  // Two guard bits above the wider operand keep base+up-down exact.
  localparam int w = ((cw > sw) ? cw : sw) + 2;
  localparam int m = max_val_p + 1;
  localparam bit wrap = (mode_p == e_counter_wrap);
  localparam bit pow2 = ((m & (m - 1)) == 0);

  localparam logic signed [w-1:0] max_s = w'(max_val_p);
  localparam logic signed [w-1:0] mod_s = w'(m);

  logic [cw-1:0]       cnt_q;
  logic [cw-1:0]       cnt_n;
  logic signed [w-1:0] base;
  logic signed [w-1:0] sum;
  logic signed [w-1:0] rem;
  logic                ovf_evt;
  logic                unf_evt;

  always_comb begin
    base = '0;
    if (!clear_i)
      base = $signed({{(w-cw){1'b0}}, cnt_q});
    sum = base
        + $signed({{(w-sw){1'b0}}, up_i})
        - $signed({{(w-sw){1'b0}}, down_i});
  end

  assign ovf_evt = (sum > max_s);
  assign unf_evt = (sum < 0);

  // Signed % keeps the dividend sign; fold negatives back up.
  always_comb begin
    rem = sum % mod_s;
    if (rem < 0)
      rem = rem + mod_s;
  end

  always_comb begin
    cnt_n = cw'(sum);
    unique case (1'b1)
      (wrap && pow2):     cnt_n = cw'(sum);
      (wrap && !pow2):    cnt_n = cw'(rem);
      (!wrap && ovf_evt): cnt_n = cw'(max_val_p);
      (!wrap && unf_evt): cnt_n = '0;
      default:            cnt_n = cw'(sum);
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)
      cnt_q <= cw'(init_val_p);
    else
      cnt_q <= cnt_n;
  end

  assign count_o = cnt_q;
  assign zero_o  = (cnt_q == '0);
  assign max_o   = (cnt_q == cw'(max_val_p));

`ifdef BSG_COUNTER_STICKY_FLAGS_EN
  logic ovf_q;
  logic unf_q;

  // Clear drops the old flag, but an event in the
  // clearing cycle still sets it.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= (ovf_q & ~clear_i) | ovf_evt;
      unf_q <= (unf_q & ~clear_i) | unf_evt;
    end
  end

  assign ovf_o = ovf_q;
  assign unf_o = unf_q;
`else
  assign ovf_o = 1'b0;
  assign unf_o = 1'b0;
`endif

endmodule

// File: rtl/bsg_counter_clear_up_down_multi.sv
// Bank of els_p independent clear/up/down counters.
// Ports: clk_i, reset_n_i, bus (slave). Flags: BSG_COUNTER_STICKY_FLAGS_EN.
module bsg_counter_clear_up_down_multi
  import bsg_counter_pkg::*;
#(
  parameter int els_p      = 1,
  parameter int max_val_p  = 15,
  parameter int max_step_p = 1,
  parameter int init_val_p = 0,
  parameter bit wrap_p     = 1'b0
) (
  input logic clk_i,
  input logic reset_n_i,
  bsg_counter_clear_up_down_multi_if.slave bus
);

  localparam int cw = bsg_counter_cw(max_val_p);
  localparam int sw = bsg_counter_sw(max_step_p);

  localparam bsg_counter_mode_e mode =
    wrap_p ? e_counter_wrap : e_counter_sat;

  for (genvar k = 0; k < els_p; k++) begin : g_ch
    bsg_counter_clear_up_down_ch #(
      .max_val_p (max_val_p),
      .max_step_p(max_step_p),
      .init_val_p(init_val_p),
      .mode_p    (mode)
    ) u_ch (
      .clk_i    (clk_i),
      .reset_n_i(reset_n_i),
      .clear_i  (bus.clear_i[k]),
      .up_i     (bus.up_i[k*sw +: sw]),
      .down_i   (bus.down_i[k*sw +: sw]),
      .count_o  (bus.count_o[k*cw +: cw]),
      .zero_o   (bus.zero_o[k]),
      .max_o    (bus.max_o[k]),
      .ovf_o    (bus.ovf_o[k]),
      .unf_o    (bus.unf_o[k])
    );
  end

  a_init: assert property (
    @(posedge clk_i) disable iff (!reset_n_i)
    (init_val_p <= max_val_p));

  a_step: assert property (
    @(posedge clk_i) disable iff (!reset_n_i)
    (max_step_p >= 1));

  a_els: assert property (
    @(posedge clk_i) disable iff (!reset_n_i)
    (els_p >= 1));

endmodule

// File: tb/tb_bsg_counter_clear_up_down_multi.sv
// Bench for the counter bank: three builds (sat, wrap, pow2 wrap)
// checked against an arithmetic model plus directed literals.
module tb_bsg_counter_clear_up_down_multi;

  localparam int CW = 4;
  localparam int SW = 3;
  localparam int N  = 7;

  // Channels 0-3: sat max 10; 4-5: wrap max 9; 6: wrap max 15.
  localparam int MX  [N] = '{10, 10, 10, 10, 9, 9, 15};
  localparam bit WR  [N] = '{0, 0, 0, 0, 1, 1, 1};
  localparam int INI [N] = '{3, 3, 3, 3, 0, 0, 5};

  localparam bit FL =
`ifdef BSG_COUNTER_STICKY_FLAGS_EN
    1'b1;
`else
    1'b0;
`endif

  logic clk;
  logic rst_n;
  bit   live;
  int   checks;
  int   errors;

  logic [N-1:0]    clr;
  logic [N*SW-1:0] up;
  logic [N*SW-1:0] dn;

  bsg_counter_clear_up_down_multi_if #(
    .els_p(4), .max_val_p(10), .max_step_p(4)) s_if ();
  bsg_counter_clear_up_down_multi_if #(
    .els_p(2), .max_val_p(9), .max_step_p(4)) w_if ();
  bsg_counter_clear_up_down_multi_if #(
    .els_p(1), .max_val_p(15), .max_step_p(4)) p_if ();

  assign s_if.clear_i = clr[3:0];
  assign w_if.clear_i = clr[5:4];
  assign p_if.clear_i = clr[6];
  assign s_if.up_i    = up[11:0];
  assign w_if.up_i    = up[17:12];
  assign p_if.up_i    = up[20:18];
  assign s_if.down_i  = dn[11:0];
  assign w_if.down_i  = dn[17:12];
  assign p_if.down_i  = dn[20:18];

  wire [N*CW-1:0] cnt =
    {p_if.count_o, w_if.count_o, s_if.count_o};
  wire [N-1:0] zro = {p_if.zero_o, w_if.zero_o, s_if.zero_o};
  wire [N-1:0] mxo = {p_if.max_o, w_if.max_o, s_if.max_o};
  wire [N-1:0] ovf = {p_if.ovf_o, w_if.ovf_o, s_if.ovf_o};
  wire [N-1:0] unf = {p_if.unf_o, w_if.unf_o, s_if.unf_o};

  bsg_counter_clear_up_down_multi #(
    .els_p(4), .max_val_p(10), .max_step_p(4),
    .init_val_p(3), .wrap_p(1'b0)
  ) dut_s (
    .clk_i(clk), .reset_n_i(rst_n), .bus(s_if.slave));

  bsg_counter_clear_up_down_multi #(
    .els_p(2), .max_val_p(9), .max_step_p(4),
    .init_val_p(0), .wrap_p(1'b1)
  ) dut_w (
    .clk_i(clk), .reset_n_i(rst_n), .bus(w_if.slave));

  bsg_counter_clear_up_down_multi #(
    .els_p(1), .max_val_p(15), .max_step_p(4),
    .init_val_p(5), .wrap_p(1'b1)
  ) dut_p (
    .clk_i(clk), .reset_n_i(rst_n), .bus(p_if.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int mc [N];
  bit mo [N];
  bit mu [N];

  function automatic int sm(input int k);
    int b;
    b = clr[k] ? 0 : mc[k];
    return b + int'(up[k*SW +: SW]) - int'(dn[k*SW +: SW]);
  endfunction

  function automatic int fit(input int s, input int mx,
                             input bit wr);
    if (wr)
      return ((s % (mx + 1)) + mx + 1) % (mx + 1);
    if (s > mx)
      return mx;
    if (s < 0)
      return 0;
    return s;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        mc[k] <= INI[k];
        mo[k] <= 1'b0;
        mu[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        mc[k] <= fit(sm(k), MX[k], WR[k]);
        mo[k] <= (mo[k] && !clr[k]) || (sm(k) > MX[k]);
        mu[k] <= (mu[k] && !clr[k]) || (sm(k) < 0);
      end
    end
  end

  task automatic chk(input string nm, input int k,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s ch%0d t=%0t got=%0d want=%0d",
               nm, k, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (live) begin
      for (int k = 0; k < N; k++) begin
        chk("cnt", k, 32'(cnt[k*CW +: CW]), mc[k]);
        chk("zero", k, 32'(zro[k]), 32'(mc[k] == 0));
        chk("max", k, 32'(mxo[k]), 32'(mc[k] == MX[k]));
        chk("ovf", k, 32'(ovf[k]), 32'(FL ? mo[k] : 1'b0));
        chk("unf", k, 32'(unf[k]), 32'(FL ? mu[k] : 1'b0));
      end
    end
  end

  task automatic idle();
    clr = '0;
    up  = '0;
    dn  = '0;
  endtask

  task automatic drv(input int k, input bit c,
                     input int u, input int d);
    clr[k]          = c;
    up[k*SW +: SW]  = SW'(u);
    dn[k*SW +: SW]  = SW'(d);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string nm, input int k,
                     input logic [31:0] act, input int exp);
    chk({"lit_", nm}, k, act, exp);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    live   = 1'b0;
    rst_n  = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    live  = 1'b1;

    drv(0, 0, 4, 0);
    drv(1, 0, 1, 0);
    tick();
    tick();
    lit("cnt", 0, 32'(cnt[3:0]), 10);
    lit("cnt", 1, 32'(cnt[7:4]), 5);
    lit("ovf", 0, 32'(ovf[0]), int'(FL));

    idle();
    #2;
    rst_n = 1'b0;
    #1;
    lit("rst_cnt", 0, 32'(cnt[3:0]), 3);
    lit("rst_cnt", 1, 32'(cnt[7:4]), 3);
    lit("rst_cnt", 6, 32'(cnt[27:24]), 5);
    lit("rst_ovf", 0, 32'(ovf[0]), 0);
    lit("rst_zero", 4, 32'(zro[4]), 1);
    tick();
    rst_n = 1'b1;

    drv(0, 0, 4, 0); tick();
    drv(0, 0, 1, 0); tick();
    lit("cnt", 0, 32'(cnt[3:0]), 8);
    drv(0, 0, 4, 0); tick();
    lit("sat_cnt", 0, 32'(cnt[3:0]), 10);
    lit("sat_max", 0, 32'(mxo[0]), 1);
    lit("sat_ovf", 0, 32'(ovf[0]), int'(FL));
    drv(0, 0, 0, 4); tick();
    lit("dn_cnt", 0, 32'(cnt[3:0]), 6);
    lit("dn_ovf", 0, 32'(ovf[0]), int'(FL));
    drv(0, 1, 0, 0); tick();
    lit("clr_cnt", 0, 32'(cnt[3:0]), 0);
    lit("clr_ovf", 0, 32'(ovf[0]), 0);
    idle();

    drv(1, 0, 4, 0); tick();
    drv(1, 0, 2, 0); tick();
    lit("cnt", 1, 32'(cnt[7:4]), 9);
    drv(1, 1, 1, 0); tick();
    lit("clr_up", 1, 32'(cnt[7:4]), 1);
    drv(1, 0, 4, 0); tick();
    tick();
    lit("cnt", 1, 32'(cnt[7:4]), 9);
    drv(1, 1, 2, 2); tick();
    lit("clr_net", 1, 32'(cnt[7:4]), 0);
    lit("clr_net_unf", 1, 32'(unf[1]), 0);
    drv(1, 1, 0, 1); tick();
    lit("clr_dn", 1, 32'(cnt[7:4]), 0);
    lit("clr_dn_unf", 1, 32'(unf[1]), int'(FL));
    idle();

    drv(4, 0, 4, 0); tick();
    tick();
    drv(4, 0, 3, 0); tick();
    lit("wrap_up", 4, 32'(cnt[19:16]), 1);
    lit("wrap_ovf", 4, 32'(ovf[4]), int'(FL));
    drv(4, 0, 0, 2); tick();
    lit("wrap_dn", 4, 32'(cnt[19:16]), 9);
    lit("wrap_unf", 4, 32'(unf[4]), int'(FL));
    drv(4, 1, 0, 2); tick();
    lit("wrap_clr_dn", 4, 32'(cnt[19:16]), 8);
    lit("wrap_clr_ovf", 4, 32'(ovf[4]), 0);
    lit("wrap_clr_unf", 4, 32'(unf[4]), int'(FL));
    lit("indep_zero", 5, 32'(zro[5]), 1);
    idle();

    drv(6, 0, 4, 0); tick();
    tick();
    tick();
    lit("p2_up", 6, 32'(cnt[27:24]), 1);
    drv(6, 0, 0, 4); tick();
    lit("p2_dn", 6, 32'(cnt[27:24]), 13);
    idle();

    repeat (10000) begin
      for (int k = 0; k < N; k++)
        drv(k, ($urandom_range(7) == 0),
            $urandom_range(4), $urandom_range(4));
      tick();
    end
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
